// File: rtl/muldiv_pkg.sv
// Shared types and operation-decode helpers for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } state_e;

    function automatic logic is_div(input op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic is_rem(input op_e op);
        return op inside {OP_REM, OP_REMU};
    endfunction

    function automatic logic is_signed_a(input op_e op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_signed_b(input op_e op);
        return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on the 2*WIDTH+1 accumulator: shift-add multiply or restoring divide.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH:0] acc,
    input  logic [WIDTH-1:0] operand,
    input  logic             div_mode,
    output logic [2*WIDTH:0] acc_next
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [2*WIDTH:0] sh;

    // Multiply: low half holds the multiplier, shifted out LSB first.
    // Divide: remainder in the high half, quotient bits enter at the LSB.
    always_comb begin
        sum      = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, operand} : '0);
        sh       = {acc[2*WIDTH-1:0], 1'b0};
        diff     = sh[2*WIDTH:WIDTH] - {1'b0, operand};
        acc_next = {1'b0, sum, acc[WIDTH-1:1]};
        if (div_mode) begin
            if (sh[2*WIDTH:WIDTH] >= {1'b0, operand}) begin
                acc_next = {diff, sh[WIDTH-1:1], 1'b1};
            end else begin
                acc_next = sh;
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit: magnitude iteration, sign fixup, result handshake.
// Handshake: a request is taken on an edge with in_valid && in_ready && !flush; a result is
// taken on an edge with out_valid && out_ready, and out_valid/result hold until then.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

    state_e             state, state_next;
    op_e                op_in, op_q;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH:0]   acc, acc_step;
    logic [WIDTH-1:0]   mag_a, mag_b, res_q;
    logic [WIDTH-1:0]   abs_a, abs_b, fast_res, fix_res, quo, rem;
    logic [2*WIDTH-1:0] prod;
    logic               neg_a, neg_b, sign_a_in, sign_b_in;
    logic               accept, div_zero, div_ovf, fast;

    assign op_in     = op_e'(op);
    assign accept    = in_valid && (state == IDLE) && !flush;
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign result    = res_q;

    always_comb begin
        sign_a_in = is_signed_a(op_in) && src_a[WIDTH-1];
        sign_b_in = is_signed_b(op_in) && src_b[WIDTH-1];
        abs_a     = sign_a_in ? -src_a : src_a;
        abs_b     = sign_b_in ? -src_b : src_b;
        div_zero  = (src_b == '0);
        div_ovf   = is_signed_b(op_in) && (src_a == MIN_INT) && (src_b == '1);
        fast      = is_div(op_in) && (div_zero || div_ovf);
        if (is_rem(op_in)) begin
            fast_res = div_zero ? src_a : '0;
        end else begin
            fast_res = div_zero ? '1 : src_a;
        end
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc),
        .operand  (is_div(op_q) ? mag_b : mag_a),
        .div_mode (is_div(op_q)),
        .acc_next (acc_step)
    );

    // Sign correction: product and quotient follow the XOR of operand signs, remainder the dividend.
    always_comb begin
        prod = acc[2*WIDTH-1:0];
        quo  = acc[WIDTH-1:0];
        rem  = acc[2*WIDTH-1:WIDTH];
        if (neg_a ^ neg_b) begin
            prod = -prod;
            quo  = -quo;
        end
        if (neg_a) begin
            rem = -rem;
        end
        case (op_q)
            OP_MUL:                      fix_res = prod[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:             fix_res = quo;
            default:                     fix_res = rem;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = fast ? DONE : CALC;
            CALC:    if (cnt == CNT_W'(1)) state_next = FIXUP;
            FIXUP:   state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            op_q  <= OP_MUL;
            cnt   <= '0;
            acc   <= '0;
            mag_a <= '0;
            mag_b <= '0;
            neg_a <= 1'b0;
            neg_b <= 1'b0;
            res_q <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q  <= op_in;
                        neg_a <= sign_a_in;
                        neg_b <= sign_b_in;
                        mag_a <= abs_a;
                        mag_b <= abs_b;
                        cnt   <= CNT_W'(WIDTH);
                        acc   <= {{(WIDTH+1){1'b0}}, is_div(op_in) ? abs_a : abs_b};
                        if (fast) begin
                            res_q <= fast_res;
                        end
                    end
                end
                CALC: begin
                    acc <= acc_step;
                    cnt <= cnt - CNT_W'(1);
                end
                FIXUP: begin
                    if (!flush) begin
                        res_q <= fix_res;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised, multi-cycle integer multiply/divide unit implementing the RV32M operation set; successor to the single-cycle combinational ALU.
- Sits beside the ALU in the execute stage. The core stalls on in_ready/out_valid.
- Iterative radix-2 shift-add multiplier and restoring divider share one accumulator datapath.
- Divide-by-zero and signed overflow take a one-cycle fast path.

Parameters:
- WIDTH, 32, operand/result width in bits (>=4, even).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden).

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept; high only in IDLE.
- op  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- src_a  in  WIDTH  rs1 operand (multiplicand/dividend).
- src_b  in  WIDTH  rs2 operand (multiplier/divisor).
- flush  in  1  kill in-flight operation (pipeline squash).
- out_valid  out  1  result available; held until taken.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  operation result.
- busy  out  1  high in CALC, FIXUP or DONE.

Behaviour:
- Reset (async assert, sync-safe deassert): state=IDLE, counter=0, accumulator=0. Outputs: in_ready=1, out_valid=0, result=0, busy=0.
- Accept: on a rising edge with in_valid && in_ready && !flush, latch op, operand signs, and absolute values (signed ops: MUL/MULH both signed, MULHSU src_a signed only, DIV/REM signed).
- States and transitions:
  - IDLE: on accept, go to DONE (fast path) or CALC (counter=WIDTH).
  - CALC: one shift-add or shift-subtract step per cycle, counter decrements; counter reaches 1 -> FIXUP.
  - FIXUP: apply sign correction (two's-complement negate of product, quotient and/or remainder as required), select result word -> DONE.
  - DONE: out_valid=1, result stable; out_valid && out_ready -> IDLE.
- Latency: normal ops present out_valid exactly WIDTH+2 cycles after the accept edge (34 at WIDTH=32). Fast path presents it 1 cycle after the accept edge.
- Fast path cases:
  - DIV/DIVU with src_b=0: quotient = all ones.
  - REM/REMU with src_b=0: remainder = src_a.
  - DIV with src_a=100..0 and src_b=all ones: quotient = src_a.
  - REM with the same operands: remainder = 0.
- Result selection:
  - MUL: low WIDTH bits of the 2*WIDTH product.
  - MULH/MULHSU/MULHU: high WIDTH bits.
  - DIV/DIVU: quotient truncated toward zero.
  - REM/REMU: remainder takes the sign of the dividend.
- Backpressure: DONE holds result and out_valid indefinitely while out_ready=0; in_ready stays 0.
- Back-to-back: no new accept in the same cycle as the result handoff; the earliest next accept is the cycle after returning to IDLE.
- Flush:
  - Any state -> IDLE on the next edge; out_valid=0 from that edge. A flushed result is never presented.
  - Flush in IDLE with in_valid blocks the accept.
  - Flush together with out_ready in DONE -> IDLE; the result counts as dropped.
- Async reset mid-operation: immediate return to reset values; no partial result is ever visible.
- Operands may change after accept without affecting the result.

Decomposition:
- Shared package muldiv_pkg holds:
  - op_e enum (8 funct3 codes) and helpers is_div(op), is_signed_a(op), is_signed_b(op).
  - state_e {IDLE, CALC, FIXUP, DONE}.
- Natural sub-module: muldiv_step, the combinational single-iteration shift-add/restoring-subtract slice on the 2*WIDTH+1 accumulator. FSM, counter and sign fixup stay in muldiv_unit.

Test Plan:
- Multiply (WIDTH=32):
  - MUL 7 * 0xFFFFFFFD -> result 0xFFFFFFEB; out_valid exactly 34 cycles after accept.
  - MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
  - MULH same operands -> 0x00000000.
  - MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF.
- Signed divide: DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
- Fast path, each with out_valid 1 cycle after accept:
  - DIVU 5/0 -> 0xFFFFFFFF.
  - REM 5/0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
  - REM same -> 0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> result stable, in_ready=0. Pulse out_ready -> IDLE the next cycle, then the next op is accepted.
- Flush/reset:
  - Flush at CALC cycle 10 -> out_valid never asserts, in_ready=1 next cycle; following MUL 3*4 -> 12.
  - rst_n low mid-CALC -> outputs at reset values immediately.
